bomb_scheduler: RTL and testbench

Sequences and arbitrates the two shared bomb slots in the Bomberman game logic. It accepts drop requests from both players, grants free slots, and runs each slot's fuse/blast/clear lifecycle. It drives the 5-bit `bomb_state` code and the `make` strobe into each bomb datapath instance. Clocked by the frame clock, it sits between the player/keyboard logic and the bomb datapaths, and also feeds the explosion renderer and the collision logic.

---
 rtl/bomb_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: grants the two shared bomb slots and sequences each slot IDLE->ARMED->EXPLODE->CLEAR; all outputs registered, decisions 1 cycle after the request edge.
// No backpressure: a request edge is granted or denied at once and never queued. BOMB_CHAIN_EN enables chain detonation from the slot positions.
module bomb_scheduler #(
  parameter int FUSE_FRAMES    = 120,
  parameter int BLAST_FRAMES   = 30,
  parameter int BLAST_RANGE    = 64,
  parameter int PER_PLAYER_MAX = 1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] drop_req,
  input  logic [9:0] bomb0X,
  input  logic [9:0] bomb0Y,
  input  logic [9:0] bomb1X,
  input  logic [9:0] bomb1Y,
  output logic [4:0] bomb_state0,
  output logic [4:0] bomb_state1,
  output logic [1:0] make,
  output logic [1:0] slot_owner,
  output logic [1:0] grant,
  output logic [1:0] deny,
  output logic       explode_any
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00000,
    S_ARMED   = 5'b00001,
    S_EXPLODE = 5'b00010,
    S_CLEAR   = 5'b00011
  } slot_state_t;

  localparam logic [7:0]  FUSE_LOAD   = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0]  BLAST_LOAD  = 8'(BLAST_FRAMES - 1);
  localparam logic [1:0]  OWN_MAX     = 2'(PER_PLAYER_MAX);
  localparam logic [10:0] CHAIN_RANGE = 11'(BLAST_RANGE);

  slot_state_t st     [2];
  slot_state_t st_nxt [2];
  logic [7:0]  cnt     [2];
  logic [7:0]  cnt_nxt [2];
  logic [1:0]  own_cnt [2];
  logic [1:0]  owner, owner_nxt;
  logic [1:0]  prev_req, req_edge, eligible, req_ok, free_slot;
  logic [1:0]  take, take_who, chain, grant_nxt, deny_nxt;
  logic        pri, pri_nxt;

  assign req_edge  = drop_req & ~prev_req;
  assign free_slot = {st[1] == S_IDLE, st[0] == S_IDLE};
  assign req_ok    = req_edge & eligible;

  // A slot in CLEAR still counts against its owner.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      own_cnt[p] = 2'd0;
      for (int i = 0; i < 2; i++)
        if (st[i] != S_IDLE && owner[i] == p[0])
          own_cnt[p] = own_cnt[p] + 2'd1;
      eligible[p] = own_cnt[p] < OWN_MAX;
    end
  end

  always_comb begin
    take      = 2'b00;
    take_who  = 2'b00;
    grant_nxt = 2'b00;
    deny_nxt  = req_edge & ~eligible;
    pri_nxt   = pri;
    case (req_ok)
      2'b01, 2'b10: begin
        if (free_slot[0]) begin
          take[0]     = 1'b1;
          take_who[0] = req_ok[1];
          grant_nxt   = req_ok;
        end else if (free_slot[1]) begin
          take[1]     = 1'b1;
          take_who[1] = req_ok[1];
          grant_nxt   = req_ok;
        end else begin
          deny_nxt = deny_nxt | req_ok;
        end
      end
      2'b11: begin
        pri_nxt = ~pri;
        if (&free_slot) begin
          take      = 2'b11;
          take_who  = {~pri, pri};
          grant_nxt = 2'b11;
        end else if (|free_slot) begin
          take            = free_slot;
          take_who        = {pri, pri};
          grant_nxt[pri]  = 1'b1;
          deny_nxt[~pri]  = 1'b1;
        end else begin
          deny_nxt = 2'b11;
        end
      end
      default: ;
    endcase
  end

`ifdef BOMB_CHAIN_EN
  logic [9:0] dx, dy;
  logic       near;

  assign dx   = (bomb0X > bomb1X) ? bomb0X - bomb1X : bomb1X - bomb0X;
  assign dy   = (bomb0Y > bomb1Y) ? bomb0Y - bomb1Y : bomb1Y - bomb0Y;
  assign near = (dy < 10'd16 && {1'b0, dx} <= CHAIN_RANGE) ||
                (dx < 10'd16 && {1'b0, dy} <= CHAIN_RANGE);
  assign chain[0] = near && st[0] == S_ARMED && st[1] == S_EXPLODE;
  assign chain[1] = near && st[1] == S_ARMED && st[0] == S_EXPLODE;
`else
  logic unused_pos;
  assign unused_pos = ^{bomb0X, bomb0Y, bomb1X, bomb1Y, CHAIN_RANGE};
  assign chain      = 2'b00;
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nxt[i]    = st[i];
      cnt_nxt[i]   = cnt[i];
      owner_nxt[i] = owner[i];
      if (take[i]) begin
        st_nxt[i]    = S_ARMED;
        cnt_nxt[i]   = FUSE_LOAD;
        owner_nxt[i] = take_who[i];
      end else begin
        case (st[i])
          S_ARMED: begin
            if (chain[i] || cnt[i] == 8'd0) begin
              st_nxt[i]  = S_EXPLODE;
              cnt_nxt[i] = BLAST_LOAD;
            end else begin
              cnt_nxt[i] = cnt[i] - 8'd1;
            end
          end
          S_EXPLODE: begin
            if (cnt[i] == 8'd0) st_nxt[i] = S_CLEAR;
            else                cnt_nxt[i] = cnt[i] - 8'd1;
          end
          S_CLEAR: st_nxt[i] = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  // prev_req resets high so a button held through reset cannot drop a bomb.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= 8'd0;
      end
      owner       <= 2'b00;
      prev_req    <= 2'b11;
      pri         <= 1'b0;
      make        <= 2'b00;
      grant       <= 2'b00;
      deny        <= 2'b00;
      explode_any <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
      owner       <= owner_nxt;
      prev_req    <= drop_req;
      pri         <= pri_nxt;
      make        <= take;
      grant       <= grant_nxt;
      deny        <= deny_nxt;
      explode_any <= (st_nxt[0] == S_EXPLODE) || (st_nxt[1] == S_EXPLODE);
    end
  end

  assign bomb_state0 = st[0];
  assign bomb_state1 = st[1];
  assign slot_owner  = owner;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: vector table, hand-written lifecycle/contest/reset/chain sequences, and random traffic against a slot-age model.
module tb_bomb_scheduler;

  localparam int F2 = 4;
  localparam int B2 = 3;
  localparam int MAX2 = 2;

  logic       clk = 1'b0;
  logic       Reset;
  logic [1:0] req1, req2;
  logic [9:0] b0x, b0y, b1x, b1y;
  logic [4:0] s10, s11, s20, s21;
  logic [1:0] mk1, own1, gr1, dn1, mk2, own2, gr2, dn2;
  logic       ex1, ex2;

  always #5 clk = ~clk;

  bomb_scheduler u_dut (
    .frame_clk(clk), .Reset(Reset), .drop_req(req1),
    .bomb0X(b0x), .bomb0Y(b0y), .bomb1X(b1x), .bomb1Y(b1y),
    .bomb_state0(s10), .bomb_state1(s11), .make(mk1), .slot_owner(own1),
    .grant(gr1), .deny(dn1), .explode_any(ex1)
  );

  bomb_scheduler #(.FUSE_FRAMES(F2), .BLAST_FRAMES(B2), .PER_PLAYER_MAX(MAX2)) u_dut2 (
    .frame_clk(clk), .Reset(Reset), .drop_req(req2),
    .bomb0X(10'd0), .bomb0Y(10'd0), .bomb1X(10'd500), .bomb1Y(10'd500),
    .bomb_state0(s20), .bomb_state1(s21), .make(mk2), .slot_owner(own2),
    .grant(gr2), .deny(dn2), .explode_any(ex2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all;
    Reset = 1'b1;
    req1  = 2'b00;
    req2  = 2'b00;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic run_len(input logic [4:0] code, output int n);
    n = 0;
    while (s10 == code && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_s10(input logic [4:0] code);
    int n = 0;
    while (s10 != code && n < 400) begin
      n++;
      tick();
    end
    chk("wait_state0", s10, code);
  endtask

  // Reference model: a slot is remembered by the cycle its ARMED phase began.
  int         m_start [2];
  logic       m_owner [2];
  logic       m_pri;
  logic [1:0] m_prev;
  int         cyc = 0;

  function automatic int mst(int i, int k);
    int a;
    if (m_start[i] < 0) return 0;
    a = k - m_start[i];
    if (a < F2) return 1;
    if (a < F2 + B2) return 2;
    if (a == F2 + B2) return 3;
    return 0;
  endfunction

  task automatic model_step(input logic rst, input logic [1:0] req,
                            output logic [1:0] eg, output logic [1:0] ed, output logic [1:0] em);
    int q_free[$];
    int q_req[$];
    int own[2];
    int k = cyc;
    logic [1:0] edg;
    eg = 2'b00; ed = 2'b00; em = 2'b00;
    if (rst) begin
      m_start[0] = -1; m_start[1] = -1;
      m_owner[0] = 1'b0; m_owner[1] = 1'b0;
      m_pri = 1'b0;
      m_prev = 2'b11;
    end else begin
      edg = req & ~m_prev;
      m_prev = req;
      for (int p = 0; p < 2; p++) begin
        own[p] = 0;
        for (int i = 0; i < 2; i++)
          if (mst(i, k) != 0 && m_owner[i] == p[0]) own[p]++;
      end
      for (int i = 0; i < 2; i++)
        if (mst(i, k) == 0) q_free.push_back(i);
      for (int p = 0; p < 2; p++)
        if (edg[p] && own[p] >= MAX2) ed[p] = 1'b1;
      if (edg[0] && own[0] < MAX2 && edg[1] && own[1] < MAX2) begin
        q_req.push_back(int'(m_pri));
        q_req.push_back(int'(~m_pri));
        m_pri = ~m_pri;
      end else begin
        for (int p = 0; p < 2; p++)
          if (edg[p] && own[p] < MAX2) q_req.push_back(p);
      end
      foreach (q_req[r]) begin
        int p = q_req[r];
        if (q_free.size() > 0) begin
          int s = q_free.pop_front();
          m_start[s] = k + 1;
          m_owner[s] = p[0];
          eg[p] = 1'b1;
          em[s] = 1'b1;
        end else begin
          ed[p] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] dny;
    logic [1:0] mk;
    logic [1:0] own;
    logic [4:0] s0;
    logic [4:0] s1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    logic [1:0] eg, ed, em;
    logic rr;

    tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0};
    tbl[1] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 5'd1, 5'd0};
    tbl[2] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5'd1, 5'd0};
    tbl[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'd1, 5'd0};
    tbl[4] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 5'd1, 5'd0};
    tbl[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'd1, 5'd0};
    tbl[6] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 5'd1, 5'd1};
    tbl[7] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 5'd1, 5'd1};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 5'd1, 5'd1};
    tbl[9] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 5'd1, 5'd1};

    b0x = 10'd100; b0y = 10'd100; b1x = 10'd500; b1y = 10'd500;
    Reset = 1'b1; req1 = 2'b11; req2 = 2'b11;
    tick();
    chk("rst_state0", s10, 5'd0);
    chk("rst_state1", s11, 5'd0);
    chk("rst_make", mk1, 2'b00);
    chk("rst_grant", gr1, 2'b00);
    chk("rst_deny", dn1, 2'b00);
    chk("rst_owner", own1, 2'b00);
    chk("rst_explode", ex1, 1'b0);
    chk("rst2_state", {s21, s20}, 10'd0);

    // Vector table, starting straight after reset release.
    Reset = 1'b0;
    foreach (tbl[v]) begin
      req1 = tbl[v].req;
      tick();
      chk($sformatf("vec%0d_grant", v), gr1, tbl[v].gnt);
      chk($sformatf("vec%0d_deny", v), dn1, tbl[v].dny);
      chk($sformatf("vec%0d_make", v), mk1, tbl[v].mk);
      chk($sformatf("vec%0d_owner", v), own1, tbl[v].own);
      chk($sformatf("vec%0d_state", v), {s11, s10}, {tbl[v].s1, tbl[v].s0});
    end

    // Full lifecycle, then re-grant in the first IDLE cycle.
    reset_all();
    req1 = 2'b01;
    tick();
    chk("life_grant", gr1, 2'b01);
    chk("life_make", mk1, 2'b01);
    req1 = 2'b00;
    run_len(5'd1, n);
    chk("armed_len", n, 120);
    chk("explode_any_on", ex1, 1'b1);
    run_len(5'd2, n);
    chk("explode_len", n, 30);
    chk("explode_any_off", ex1, 1'b0);
    run_len(5'd3, n);
    chk("clear_len", n, 1);
    chk("idle_after_clear", s10, 5'd0);
    req1 = 2'b01;
    tick();
    chk("regrant_state", s10, 5'd1);
    chk("regrant_grant", gr1, 2'b01);
    req1 = 2'b00;

    // Simultaneous requests with both slots free.
    reset_all();
    req1 = 2'b11;
    tick();
    chk("both_grant", gr1, 2'b11);
    chk("both_make", mk1, 2'b11);
    chk("both_owner", own1, 2'b10);
    chk("both_deny", dn1, 2'b00);
    chk("both_state", {s11, s10}, {5'd1, 5'd1});

    // Contests with one free slot: priority alternates.
    reset_all();
    req2 = 2'b01; tick();
    req2 = 2'b00; tick();
    req2 = 2'b11; tick();
    chk("contest1_grant", gr2, 2'b01);
    chk("contest1_deny", dn2, 2'b10);
    chk("contest1_make", mk2, 2'b10);
    req2 = 2'b00;
    n = 0;
    while (s20 != 5'd0 && n < 50) begin
      n++;
      tick();
    end
    req2 = 2'b11; tick();
    chk("contest2_grant", gr2, 2'b10);
    chk("contest2_deny", dn2, 2'b01);
    chk("contest2_make", mk2, 2'b01);
    chk("contest2_owner0", own2[0], 1'b1);
    req2 = 2'b00;

`ifdef BOMB_CHAIN_EN
    for (int c = 0; c < 2; c++) begin
      reset_all();
      b0x = 10'd100; b0y = 10'd100;
      b1x = (c == 0) ? 10'd150 : 10'd200;
      b1y = (c == 0) ? 10'd104 : 10'd100;
      req1 = 2'b01; tick();
      req1 = 2'b00; tick();
      req1 = 2'b10; tick();
      req1 = 2'b00;
      wait_s10(5'd2);
      chk("chain_pre", s11, 5'd1);
      tick();
      chk(c == 0 ? "chain_hit" : "chain_miss", s11, c == 0 ? 5'd2 : 5'd1);
    end
    b1x = 10'd500; b1y = 10'd500;
`endif

    // Reset during EXPLODE with both buttons held through release.
    reset_all();
    req1 = 2'b01; tick();
    req1 = 2'b00;
    wait_s10(5'd2);
    req1 = 2'b11;
    Reset = 1'b1;
    tick();
    chk("midrst_state", {s11, s10}, 10'd0);
    chk("midrst_outs", {mk1, gr1, dn1, own1, ex1}, 9'd0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_no_grant", {gr1, s10}, 7'd0);
    end
    req1 = 2'b00;

    // Random traffic on the short-timer instance against the model.
    Reset = 1'b1;
    model_step(1'b1, req2, eg, ed, em);
    tick();
    for (int t = 0; t < 3000; t++) begin
      rr = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) == 0) req2[p] = ~req2[p];
      Reset = rr;
      model_step(rr, req2, eg, ed, em);
      tick();
      chk("rnd_grant", gr2, eg);
      chk("rnd_deny", dn2, ed);
      chk("rnd_make", mk2, em);
      chk("rnd_state0", s20, 5'(mst(0, cyc)));
      chk("rnd_state1", s21, 5'(mst(1, cyc)));
      chk("rnd_owner", own2, {m_owner[1], m_owner[0]});
      chk("rnd_explode", ex2, (mst(0, cyc) == 2) || (mst(1, cyc) == 2));
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
